// File: rtl/pe_array_controller_pkg.sv
// Shared types and default geometry for the PE array controller.
package pe_array_controller_pkg;

    localparam int unsigned DEF_NUM_ROWS  = 3;
    localparam int unsigned DEF_FILTER_W  = 3;
    localparam int unsigned DEF_NUM_DIAGS = 5;
    localparam int unsigned DEF_IFMAP_W   = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILTER,
        LOAD_IFMAP,
        CONV,
        DONE
    } pe_ctrl_state_t;

    // True when cnt lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input int unsigned cnt, input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/pe_array_controller_if.sv
// Control bundle between the tile FSM / operand source and the PE array controller.
interface pe_array_controller_if
    import pe_array_controller_pkg::*;
#(
    parameter int unsigned NUM_ROWS  = DEF_NUM_ROWS,
    parameter int unsigned NUM_DIAGS = DEF_NUM_DIAGS
) ();

    logic                 start;
    logic                 reuse_filter;
    logic                 src_valid;
    logic                 src_ready;
    logic [NUM_ROWS-1:0]  read_new_filter_val;
    logic [NUM_DIAGS-1:0] read_new_ifmap_val;
    logic [NUM_DIAGS-1:0] start_conv;
    logic                 busy;
    logic                 done;

    modport master (
        output start, reuse_filter, src_valid,
        input  src_ready, read_new_filter_val, read_new_ifmap_val, start_conv, busy, done
    );

    modport slave (
        input  start, reuse_filter, src_valid,
        output src_ready, read_new_filter_val, read_new_ifmap_val, start_conv, busy, done
    );

endinterface

// File: rtl/pe_ctrl_nested_cnt.sv
// Two-level counter: inner wraps at INNER_MAX and carries into outer, which wraps at OUTER_MAX.
module pe_ctrl_nested_cnt #(
    parameter int unsigned INNER_MAX = 2,
    parameter int unsigned OUTER_MAX = 2,
    localparam int unsigned IW = (INNER_MAX > 0) ? $clog2(INNER_MAX + 1) : 1,
    localparam int unsigned OW = (OUTER_MAX > 0) ? $clog2(OUTER_MAX + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [IW-1:0] inner,
    output logic [OW-1:0] outer,
    output logic          last
);

    logic inner_wrap;
    logic outer_wrap;

    assign inner_wrap = (inner == IW'(INNER_MAX));
    assign outer_wrap = (outer == OW'(OUTER_MAX));
    assign last       = inner_wrap && outer_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            inner <= '0;
            outer <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner <= '0;
                outer <= outer_wrap ? '0 : outer + OW'(1);
            end else begin
                inner <= inner + IW'(1);
            end
        end
    end

endmodule

// File: rtl/pe_array_controller.sv
// Sequencer for PE filter/ifmap loading and the diagonal-skewed conv wave.
// Optional feature macro: PE_CTRL_FILTER_REUSE_EN (start with reuse_filter skips the filter load).
module pe_array_controller
    import pe_array_controller_pkg::*;
#(
    parameter int unsigned NUM_ROWS  = DEF_NUM_ROWS,
    parameter int unsigned FILTER_W  = DEF_FILTER_W,
    parameter int unsigned NUM_DIAGS = DEF_NUM_DIAGS,
    parameter int unsigned IFMAP_W   = DEF_IFMAP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pe_array_controller_if.slave  bus
);

    localparam int unsigned CONV_LAST = NUM_DIAGS + IFMAP_W - 2;
    localparam int unsigned CW        = $clog2(CONV_LAST + 1);
    localparam int unsigned FWW       = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
    localparam int unsigned FRW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned IWW       = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1;
    localparam int unsigned IDW       = (NUM_DIAGS > 1) ? $clog2(NUM_DIAGS) : 1;

    pe_ctrl_state_t       state;
    logic [CW-1:0]        conv_cnt;
    logic [CW-1:0]        conv_nxt;
    logic [NUM_DIAGS-1:0] start_conv_q;
    logic [NUM_DIAGS-1:0] wave_next;
    logic                 done_q;

    logic                 src_ready;
    logic                 xfer;
    logic                 cnt_clr;
    logic [FWW-1:0]       f_word;
    logic [FRW-1:0]       f_row;
    logic                 f_last;
    logic [IWW-1:0]       i_word;
    logic [IDW-1:0]       i_diag;
    logic                 i_last;
    logic [NUM_ROWS-1:0]  filter_stb;
    logic [NUM_DIAGS-1:0] ifmap_stb;

    assign src_ready = (state == LOAD_FILTER) || (state == LOAD_IFMAP);
    assign xfer      = bus.src_valid && src_ready;
    assign cnt_clr   = (state == DONE);

    pe_ctrl_nested_cnt #(
        .INNER_MAX (FILTER_W - 1),
        .OUTER_MAX (NUM_ROWS - 1)
    ) u_filter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer && (state == LOAD_FILTER)),
        .clr   (cnt_clr),
        .inner (f_word),
        .outer (f_row),
        .last  (f_last)
    );

    pe_ctrl_nested_cnt #(
        .INNER_MAX (IFMAP_W - 1),
        .OUTER_MAX (NUM_DIAGS - 1)
    ) u_ifmap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer && (state == LOAD_IFMAP)),
        .clr   (cnt_clr),
        .inner (i_word),
        .outer (i_diag),
        .last  (i_last)
    );

    // Word position only drives the carry inside the counter.
    logic unused_words;
    assign unused_words = ^{f_word, i_word};

    // Load strobes follow src_valid in the same cycle as the data word.
    always_comb begin
        filter_stb = '0;
        ifmap_stb  = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            filter_stb[r] = (state == LOAD_FILTER) && bus.src_valid && (int'(f_row) == int'(r));
        end
        for (int unsigned d = 0; d < NUM_DIAGS; d++) begin
            ifmap_stb[d] = (state == LOAD_IFMAP) && bus.src_valid && (int'(i_diag) == int'(d));
        end
    end

    // Wave for the count that will be current after this edge.
    always_comb begin
        conv_nxt  = (state == CONV) ? conv_cnt + CW'(1) : '0;
        wave_next = '0;
        for (int unsigned d = 0; d < NUM_DIAGS; d++) begin
            wave_next[d] = in_window(int'(conv_nxt), d, IFMAP_W);
        end
    end

`ifndef PE_CTRL_FILTER_REUSE_EN
    logic unused_reuse;
    assign unused_reuse = bus.reuse_filter;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            conv_cnt     <= '0;
            start_conv_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    conv_cnt     <= '0;
                    start_conv_q <= '0;
                    if (bus.start) begin
`ifdef PE_CTRL_FILTER_REUSE_EN
                        state <= bus.reuse_filter ? LOAD_IFMAP : LOAD_FILTER;
`else
                        state <= LOAD_FILTER;
`endif
                    end
                end
                LOAD_FILTER: begin
                    if (xfer && f_last) state <= LOAD_IFMAP;
                end
                LOAD_IFMAP: begin
                    if (xfer && i_last) begin
                        state        <= CONV;
                        conv_cnt     <= '0;
                        start_conv_q <= wave_next;
                    end
                end
                CONV: begin
                    if (conv_cnt == CW'(CONV_LAST)) begin
                        state        <= DONE;
                        start_conv_q <= '0;
                        done_q       <= 1'b1;
                    end else begin
                        conv_cnt     <= conv_nxt;
                        start_conv_q <= wave_next;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    conv_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.src_ready           = src_ready;
    assign bus.read_new_filter_val = filter_stb;
    assign bus.read_new_ifmap_val  = ifmap_stb;
    assign bus.start_conv          = start_conv_q;
    assign bus.busy                = (state != IDLE);
    assign bus.done                = done_q;

endmodule

// File: tb/tb_pe_array_controller.sv
// Directed bench for pe_array_controller: checkpoint table per pass plus whole-pass statistics.
module tb_pe_array_controller;
    import pe_array_controller_pkg::*;

    localparam int NC   = 80;
    localparam int NONE = -100;

    typedef struct {
        int         pid;
        int         cyc;
        logic [2:0] f;
        logic [4:0] i;
        logic [4:0] c;
        logic       busy;
        logic       done;
        logic       rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pe_array_controller_if bus ();

    pe_array_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] tf [NC];
    logic [4:0] ti [NC];
    logic [4:0] tc [NC];
    logic       t_busy [NC];
    logic       t_done [NC];
    logic       t_rdy  [NC];

    vec_t vecs[$];

    int first_done, n_done, n_busy, n_f, n_i, bad_hot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int pid, input int cyc, input logic [2:0] f,
                                input logic [4:0] i, input logic [4:0] c, input logic busy,
                                input logic done, input logic rdy);
        vec_t v;
        v.pid = pid; v.cyc = cyc; v.f = f; v.i = i; v.c = c;
        v.busy = busy; v.done = done; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    // One pass: start sampled at posedge 0, then cycles 1..NC-1 traced at the negedge.
    task automatic run_pass(input logic reuse, input int stall_lo, input int p0, input int p1,
                            input int p2, input int rst_cyc);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.reuse_filter = reuse;
        bus.src_valid    = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n < NC; n++) begin
            bus.src_valid = !(n >= stall_lo && n < stall_lo + 4);
            bus.start     = (n == p0) || (n == p1) || (n == p2);
            rst_n         = (n != rst_cyc);
            @(negedge clk);
            tf[n]     = bus.read_new_filter_val;
            ti[n]     = bus.read_new_ifmap_val;
            tc[n]     = bus.start_conv;
            t_busy[n] = bus.busy;
            t_done[n] = bus.done;
            t_rdy[n]  = bus.src_ready;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic summarize();
        first_done = 0; n_done = 0; n_busy = 0; n_f = 0; n_i = 0; bad_hot = 0;
        for (int n = 1; n < NC; n++) begin
            if (t_done[n] === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = n;
            end
            if (t_busy[n] === 1'b1) n_busy++;
            n_f += $countones(tf[n]);
            n_i += $countones(ti[n]);
            if ($countones(tf[n]) > 1 || $countones(ti[n]) > 1) bad_hot++;
        end
    endtask

    task automatic apply_vecs(input int pid);
        foreach (vecs[k]) begin
            if (vecs[k].pid == pid) begin
                automatic int c = vecs[k].cyc;
                check($sformatf("p%0d_c%0d_filter", pid, c), 32'(tf[c]), 32'(vecs[k].f));
                check($sformatf("p%0d_c%0d_ifmap", pid, c), 32'(ti[c]), 32'(vecs[k].i));
                check($sformatf("p%0d_c%0d_conv", pid, c), 32'(tc[c]), 32'(vecs[k].c));
                check($sformatf("p%0d_c%0d_busy", pid, c), 32'(t_busy[c]), 32'(vecs[k].busy));
                check($sformatf("p%0d_c%0d_done", pid, c), 32'(t_done[c]), 32'(vecs[k].done));
                check($sformatf("p%0d_c%0d_ready", pid, c), 32'(t_rdy[c]), 32'(vecs[k].rdy));
            end
        end
    endtask

    task automatic check_stats(input int pid, input int e_done_at, input int e_ndone,
                               input int e_busy, input int e_f, input int e_i);
        summarize();
        check($sformatf("p%0d_done_cycle", pid), first_done, e_done_at);
        check($sformatf("p%0d_done_count", pid), n_done, e_ndone);
        check($sformatf("p%0d_busy_cycles", pid), n_busy, e_busy);
        check($sformatf("p%0d_filter_strobes", pid), n_f, e_f);
        check($sformatf("p%0d_ifmap_strobes", pid), n_i, e_i);
        check($sformatf("p%0d_onehot", pid), bad_hot, 0);
    endtask

    initial begin
        int c0_first, c0_cnt, c4_first, c4_last;

        // Pass 1: continuous source.
        add(1, 1, 3'b001, 5'b0, 5'b0, 1, 0, 1);
        add(1, 3, 3'b001, 5'b0, 5'b0, 1, 0, 1);
        add(1, 4, 3'b010, 5'b0, 5'b0, 1, 0, 1);
        add(1, 9, 3'b100, 5'b0, 5'b0, 1, 0, 1);
        add(1, 10, 3'b0, 5'b00001, 5'b0, 1, 0, 1);
        add(1, 17, 3'b0, 5'b00010, 5'b0, 1, 0, 1);
        add(1, 44, 3'b0, 5'b10000, 5'b0, 1, 0, 1);
        add(1, 45, 3'b0, 5'b0, 5'b00001, 1, 0, 0);
        add(1, 49, 3'b0, 5'b0, 5'b11111, 1, 0, 0);
        add(1, 52, 3'b0, 5'b0, 5'b11110, 1, 0, 0);
        add(1, 55, 3'b0, 5'b0, 5'b10000, 1, 0, 0);
        add(1, 56, 3'b0, 5'b0, 5'b00000, 1, 1, 0);
        add(1, 57, 3'b0, 5'b0, 5'b00000, 0, 0, 0);
        // Pass 3: src_valid low for cycles 20..23.
        add(3, 19, 3'b0, 5'b00010, 5'b0, 1, 0, 1);
        add(3, 20, 3'b0, 5'b00000, 5'b0, 1, 0, 1);
        add(3, 23, 3'b0, 5'b00000, 5'b0, 1, 0, 1);
        add(3, 24, 3'b0, 5'b00010, 5'b0, 1, 0, 1);
        add(3, 48, 3'b0, 5'b10000, 5'b0, 1, 0, 1);
        add(3, 49, 3'b0, 5'b0, 5'b00001, 1, 0, 0);
        add(3, 60, 3'b0, 5'b0, 5'b00000, 1, 1, 0);
        // Pass 4: stray starts at 5, 47, 56.
        add(4, 57, 3'b0, 5'b0, 5'b0, 0, 0, 0);
        add(4, 60, 3'b0, 5'b0, 5'b0, 0, 0, 0);
        // Pass 5: reset sampled at the edge ending cycle 48.
        add(5, 48, 3'b0, 5'b0, 5'b01111, 1, 0, 0);
        add(5, 49, 3'b0, 5'b0, 5'b00000, 0, 0, 0);
`ifdef PE_CTRL_FILTER_REUSE_EN
        add(6, 1, 3'b0, 5'b00001, 5'b0, 1, 0, 1);
        add(6, 47, 3'b0, 5'b0, 5'b0, 1, 1, 0);
`else
        add(6, 1, 3'b001, 5'b0, 5'b0, 1, 0, 1);
        add(6, 56, 3'b0, 5'b0, 5'b0, 1, 1, 0);
`endif

        bus.start        = 1'b0;
        bus.reuse_filter = 1'b0;
        bus.src_valid    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_ready", 32'(bus.src_ready), 0);
        check("reset_strobes", 32'({bus.read_new_filter_val, bus.read_new_ifmap_val}), 0);
        check("reset_conv", 32'(bus.start_conv), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_ready", 32'(bus.src_ready), 0);

        run_pass(1'b0, NONE, NONE, NONE, NONE, NONE);
        apply_vecs(1);
        check_stats(1, 56, 1, 56, 9, 35);
        c0_first = 0; c0_cnt = 0; c4_first = 0; c4_last = 0;
        for (int n = 1; n < NC; n++) begin
            if (tc[n][0] === 1'b1) begin
                c0_cnt++;
                if (c0_first == 0) c0_first = n;
            end
            if (tc[n][4] === 1'b1) begin
                if (c4_first == 0) c4_first = n;
                c4_last = n;
            end
        end
        check("p1_conv0_first", c0_first, 45);
        check("p1_conv0_len", c0_cnt, 7);
        check("p1_conv4_first", c4_first, 49);
        check("p1_conv4_last", c4_last, 55);

        run_pass(1'b0, 20, NONE, NONE, NONE, NONE);
        apply_vecs(3);
        check_stats(3, 60, 1, 60, 9, 35);

        run_pass(1'b0, NONE, 5, 47, 56, NONE);
        apply_vecs(4);
        check_stats(4, 56, 1, 56, 9, 35);

        run_pass(1'b0, NONE, NONE, NONE, NONE, 48);
        apply_vecs(5);
        check_stats(5, 0, 0, 48, 9, 35);
        run_pass(1'b0, NONE, NONE, NONE, NONE, NONE);
        check_stats(15, 56, 1, 56, 9, 35);

        run_pass(1'b1, NONE, NONE, NONE, NONE, NONE);
        apply_vecs(6);
`ifdef PE_CTRL_FILTER_REUSE_EN
        check_stats(6, 47, 1, 47, 0, 35);
`else
        check_stats(6, 56, 1, 56, 9, 35);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
